sipo_deser: RTL and testbench
=============================

# sipo_deser

Serial-in/parallel-out deserializer, the receiving end of the team's parallel-load shift-register serial link. It collects `WIDTH` serial bits, LSB first, into a word and presents the word on a registered parallel port with a valid/ready handshake. Assembly and output are double-buffered, so a new word can shift in while the previous one waits for the consumer. Overruns are flagged with a sticky status bit.

## Interface
- `WIDTH`, 4, word length in bits; legal range is 2 or more.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  sample enable; when low, bit capture and the bit counter freeze.
- `start`  in  1  frame start; sampled only in IDLE with `en`=1.
- `sin`  in  1  serial data in.
- `pout`  out  WIDTH  last completed word; bit 0 is the first bit received.
- `pout_valid`  out  1  `pout` holds an unconsumed word.
- `pout_ready`  in  1  consumer accepts `pout` on any edge where `pout_valid`=1.
- `busy`  out  1  high while a frame is being assembled (state SHIFT).
- `overrun`  out  1  sticky; a completed word replaced an unconsumed one.

## Operation
- Internal state:
  - shift register `shreg[WIDTH-1:0]`;
  - bit counter `cnt`, width `$clog2(WIDTH)`;
  - two-state FSM: IDLE and SHIFT.
- Reset (async, any time): FSM=IDLE, `shreg`=0, `cnt`=0, `pout`=0, `pout_valid`=0, `busy`=0, `overrun`=0.
  - A partial frame in progress is discarded.
  - A pending `pout` word is lost.
- IDLE:
  - If `start`=1 and `en`=1: capture `sin` as bit 0 (`shreg <= {sin, shreg[WIDTH-1:1]}`), set `cnt`=1, go to SHIFT.
  - Otherwise hold. `sin` is ignored.
- SHIFT:
  - `en`=1 and `cnt`<WIDTH-1: shift in `sin` and increment `cnt`.
  - `en`=1 and `cnt`=WIDTH-1 (last bit): `pout <= {sin, shreg[WIDTH-1:1]}`, `cnt`=0, go to IDLE. This is the word-complete event.
  - `en`=0: no shift and no count. State, `cnt` and `shreg` hold.
  - `start` is ignored in SHIFT.
- Output handshake, evaluated every edge:
  - Word-complete: `pout_valid`=1 next cycle, regardless of `pout_ready`.
  - No word-complete and `pout_valid`=1 and `pout_ready`=1: `pout_valid`=0. `pout` keeps its value.
  - `pout_ready` while `pout_valid`=0 has no effect.
- Overrun:
  - Set when word-complete occurs while `pout_valid`=1 and `pout_ready`=0. The new word overwrites `pout`; the latest word wins.
  - If `pout_ready`=1 on that same edge, the old word counts as accepted and no overrun is raised.
  - Cleared only by `rst`.
- The handshake is independent of `en`: the consumer can drain `pout` while capture is stalled.

## Timing
- `busy` is registered and equals (FSM==SHIFT).
- A frame with `en` held high takes WIDTH rising edges:
  - the start edge captures bit 0;
  - edge WIDTH-1 after it captures the last bit.
- `pout`/`pout_valid` update on the last-bit edge and are visible in the following cycle.
- Back-to-back frames: `start` may be asserted in the cycle right after word-complete (FSM is IDLE). This gives one word every WIDTH cycles with no gap bits.
- Each low `en` cycle in SHIFT stretches the frame by exactly one cycle.
- The consumer may hold `pout_ready` high permanently. Each word is then valid for exactly one cycle, unless the next word completes on that same edge, in which case `pout_valid` stays 1.

## Test plan
- Reset state:
  - Stimulus: assert `rst` asynchronously mid-cycle.
  - Required: `pout`=0, `pout_valid`=0, `busy`=0, `overrun`=0 immediately; no bits captured afterwards until `start`.
- Basic frame, WIDTH=4, `en`=1:
  - Stimulus: `start` with `sin` = 1,0,1,1 on four consecutive edges; `pout_ready` held 0.
  - Required: `pout`=4'b1101 and `pout_valid`=1 after the 4th edge; `busy` high for exactly 3 cycles.
- Back-to-back frames:
  - Stimulus: frames 4'hA then 4'h5, with `start` re-asserted on the cycle after completion; `pout_ready`=1 throughout.
  - Required: `pout`=4'hA for one valid cycle, then `pout`=4'h5 exactly 4 cycles later; `overrun`=0.
- Enable stall:
  - Stimulus: frame 4'h6 with `en` dropped for 3 cycles after bit 1.
  - Required: completion delayed by exactly 3 cycles; `pout`=4'h6.
- Overrun:
  - Stimulus: frame 4'h3 with `pout_ready`=0, then frame 4'hC still with `pout_ready`=0.
  - Required: `pout`=4'hC, `overrun`=1, and `overrun` stays 1 until `rst`.
  - Repeat with `pout_ready`=1 on the completion edge of 4'hC. Required: `overrun` stays 0.
- Reset mid-frame:
  - Stimulus: `rst` after 2 bits; then a new frame 4'h9.
  - Required: `pout`=4'h9; no leftover bits from the aborted frame.

Source files
------------

// File: rtl/sipo_deser_if.sv
// Handshake and serial bus for the SIPO deserializer.
// The master drives the serial stream and the consumer ready; the slave is the deserializer.
interface sipo_deser_if #(
    parameter int WIDTH = 4
) ();
    logic             en;
    logic             start;
    logic             sin;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic             busy;
    logic             overrun;

    modport master (
        output en,
        output start,
        output sin,
        output pout_ready,
        input  pout,
        input  pout_valid,
        input  busy,
        input  overrun
    );

    modport slave (
        input  en,
        input  start,
        input  sin,
        input  pout_ready,
        output pout,
        output pout_valid,
        output busy,
        output overrun
    );
endinterface

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: LSB-first frames of WIDTH bits, double-buffered
// output word with valid/ready handshake and a sticky overrun flag.
module sipo_deser #(
    parameter int WIDTH = 4
) (
    input logic        clk,
    input logic        rst,
    sipo_deser_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             word_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            cnt_q     <= '0;
            pout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            pout_q    <= pout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        pout_d    = pout_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        word_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.en && bus.start) begin
                    shreg_d = {bus.sin, shreg_q[WIDTH-1:1]};
                    cnt_d   = CW'(1);
                    state_d = StShift;
                end
            end
            StShift: begin
                if (bus.en) begin
                    if (cnt_q == CntLast) begin
                        // Last bit goes straight into the output word, not the shift register
                        pout_d    = {bus.sin, shreg_q[WIDTH-1:1]};
                        cnt_d     = '0;
                        state_d   = StIdle;
                        word_done = 1'b1;
                    end else begin
                        shreg_d = {bus.sin, shreg_q[WIDTH-1:1]};
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A simultaneous ready on the completion edge counts as accepting the old word
        if (word_done) begin
            valid_d = 1'b1;
            if (valid_q && !bus.pout_ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && bus.pout_ready) begin
            valid_d = 1'b0;
        end
    end

    assign bus.pout       = pout_q;
    assign bus.pout_valid = valid_q;
    assign bus.busy       = (state_q == StShift);
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: directed scenarios plus a randomized run against a
// frame-level reference model.
module tb_sipo_deser;
    localparam int W = 4;

    logic clk;
    logic rst;
    int unsigned n_checks;
    int unsigned n_fail;

    sipo_deser_if #(.WIDTH(W)) bus ();

    sipo_deser #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: collects received bits in a list and forms the word once full
    bit           m_bits[$];
    bit           m_busy;
    logic [W-1:0] m_pout;
    bit           m_valid;
    bit           m_ovr;

    function automatic void model_reset();
        m_bits.delete();
        m_busy  = 1'b0;
        m_pout  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endfunction

    function automatic void model_edge(bit e, bit s, bit d, bit r);
        bit           done;
        logic [W-1:0] w;
        done = 1'b0;
        w    = '0;
        if (!m_busy) begin
            if (e && s) begin
                m_bits.delete();
                m_bits.push_back(d);
                m_busy = 1'b1;
            end
        end else if (e) begin
            m_bits.push_back(d);
            if (m_bits.size() == W) begin
                for (int i = 0; i < W; i++) w[i] = m_bits[i];
                m_bits.delete();
                m_busy = 1'b0;
                done   = 1'b1;
            end
        end
        if (done) begin
            if (m_valid && !r) m_ovr = 1'b1;
            m_pout  = w;
            m_valid = 1'b1;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endfunction

    // Drive at the falling edge, clock once, return at the next falling edge
    task automatic cycle(input bit e, input bit s, input bit d, input bit r);
        bus.en         = e;
        bus.start      = s;
        bus.sin        = d;
        bus.pout_ready = r;
        @(posedge clk);
        model_edge(e, s, d, r);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse placed mid low-phase, released on a falling edge
    task automatic apply_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] w, input bit r_mid, input bit r_last);
        for (int i = 0; i < W; i++) begin
            cycle(1'b1, i == 0, w[i], (i == W - 1) ? r_last : r_mid);
        end
    endtask

    task automatic test_reset();
        send_frame(4'h7, 1'b0, 1'b0);
        send_frame(4'hB, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({bus.pout, bus.pout_valid, bus.busy, bus.overrun} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_immediate: pout=%h valid=%b busy=%b ovr=%b, required all 0",
                     bus.pout, bus.pout_valid, bus.busy, bus.overrun);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b0, 1'($urandom), 1'($urandom));
            n_checks++;
            if (bus.busy !== 1'b0 || bus.pout_valid !== 1'b0 || bus.pout !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_idle_hold: busy=%b valid=%b pout=%h, required 0/0/0",
                         bus.busy, bus.pout_valid, bus.pout);
            end
        end
    endtask

    task automatic test_basic_frame();
        bit sins[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int busy_cycles;
        apply_reset();
        busy_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, i == 0, sins[i], 1'b0);
            if (bus.busy === 1'b1) busy_cycles++;
        end
        n_checks++;
        if (bus.pout !== 4'b1101 || bus.pout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_word: pout=%b valid=%b, required 1101/1", bus.pout, bus.pout_valid);
        end
        n_checks++;
        if (busy_cycles != 3) begin
            n_fail++;
            $display("FAIL basic_busy_len: busy cycles=%0d, required 3", busy_cycles);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w2;
        int         gap;
        apply_reset();
        send_frame(4'hA, 1'b1, 1'b1);
        n_checks++;
        if (bus.pout !== 4'hA || bus.pout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: pout=%h valid=%b, required a/1", bus.pout, bus.pout_valid);
        end
        w2  = 4'h5;
        gap = -1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, i == 0, w2[i], 1'b1);
            if (i == 0) begin
                n_checks++;
                if (bus.pout_valid !== 1'b0 || bus.pout !== 4'hA) begin
                    n_fail++;
                    $display("FAIL b2b_consumed: valid=%b pout=%h, required 0/a",
                             bus.pout_valid, bus.pout);
                end
            end
            if (bus.pout_valid === 1'b1 && gap < 0) gap = i + 1;
        end
        n_checks++;
        if (gap != 4 || bus.pout !== 4'h5) begin
            n_fail++;
            $display("FAIL b2b_second: gap=%0d pout=%h, required 4/5", gap, bus.pout);
        end
        n_checks++;
        if (bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_overrun: overrun=%b, required 0", bus.overrun);
        end
    endtask

    task automatic test_enable_stall();
        bit ens[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bit sins[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int done_at;
        apply_reset();
        done_at = -1;
        for (int k = 0; k < 7; k++) begin
            cycle(ens[k], k == 0 || !ens[k], sins[k], 1'b0);
            if (bus.pout_valid === 1'b1 && done_at < 0) done_at = k + 1;
        end
        n_checks++;
        if (done_at != 7) begin
            n_fail++;
            $display("FAIL stall_latency: completed after %0d edges, required 7", done_at);
        end
        n_checks++;
        if (bus.pout !== 4'h6) begin
            n_fail++;
            $display("FAIL stall_word: pout=%h, required 6", bus.pout);
        end
    endtask

    task automatic test_overrun();
        apply_reset();
        send_frame(4'h3, 1'b0, 1'b0);
        send_frame(4'hC, 1'b0, 1'b0);
        n_checks++;
        if (bus.pout !== 4'hC || bus.overrun !== 1'b1 || bus.pout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: pout=%h ovr=%b valid=%b, required c/1/1",
                     bus.pout, bus.overrun, bus.pout_valid);
        end
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (bus.overrun !== 1'b1) begin
                n_fail++;
                $display("FAIL overrun_sticky: ovr=%b, required 1", bus.overrun);
            end
        end
        apply_reset();
        send_frame(4'h3, 1'b0, 1'b0);
        send_frame(4'hC, 1'b0, 1'b1);
        n_checks++;
        if (bus.pout !== 4'hC || bus.overrun !== 1'b0 || bus.pout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_accept_same_edge: pout=%h ovr=%b valid=%b, required c/0/1",
                     bus.pout, bus.overrun, bus.pout_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        apply_reset();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_busy: busy=%b, required 0", bus.busy);
        end
        send_frame(4'h9, 1'b0, 1'b0);
        n_checks++;
        if (bus.pout !== 4'h9 || bus.pout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_word: pout=%h valid=%b, required 9/1", bus.pout, bus.pout_valid);
        end
    endtask

    task automatic test_random();
        bit e, s, d, r;
        apply_reset();
        for (int k = 0; k < 500; k++) begin
            e = ($urandom_range(3) != 0);
            s = ($urandom_range(2) == 0);
            d = 1'($urandom);
            r = 1'($urandom);
            if (k % 100 == 50) apply_reset();
            cycle(e, s, d, r);
            n_checks++;
            if (bus.pout !== m_pout || bus.pout_valid !== m_valid || bus.busy !== m_busy ||
                bus.overrun !== m_ovr) begin
                n_fail++;
                $display("FAIL random_cyc%0d: pout=%h valid=%b busy=%b ovr=%b, required %h/%b/%b/%b",
                         k, bus.pout, bus.pout_valid, bus.busy, bus.overrun,
                         m_pout, m_valid, m_busy, m_ovr);
            end
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        bus.en         = 1'b0;
        bus.start      = 1'b0;
        bus.sin        = 1'b0;
        bus.pout_ready = 1'b0;
        rst            = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_enable_stall();
        test_overrun();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
